lift_request_scheduler: RTL
===========================

# lift_request_scheduler

Front end of the lift controller. It latches hall and cab call buttons for every floor and schedules them with direction-preserving SCAN. It drives the 2-bit floor request into the lift controller's `in` port, watches the controller's 3-bit `floor` output to detect arrival, clears served calls and holds a door-dwell interval. It is the initiator; the lift controller is the responder.

## Interface
- `NUM_FLOORS`, 4, number of floors served; request width is clog2(NUM_FLOORS) = 2.
- `DWELL_CYCLES`, 3, cycles `door_open` stays high after an arrival; must be ≥ 1.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `call` input NUM_FLOORS: one bit per floor, level or pulse, sampled every edge.
- `floor` input 3: current floor from the lift controller; values ≥ NUM_FLOORS are ignored.
- `target` output 2: floor requested from the lift; connects to the controller's `in`.
- `target_valid` output 1: `target` is a live request.
- `door_open` output 1: high during dwell.
- `dir_up` output 1: current sweep direction (1 = up).
- `pending` output NUM_FLOORS: latched outstanding calls.

## Operation
- Call latching: `pending[i]` is set one edge after `call[i]`=1. It is cleared only by service.
- Absorbed calls: `call[i]` for the floor being dwelt at while `door_open`=1 is not latched. It reloads the dwell counter instead.
- State machine states: IDLE, UP, DOWN, DWELL.
- IDLE:
  - If `pending` is empty, stay in IDLE.
  - If the pending bit at `floor` is set, go to DWELL.
  - Otherwise pick the nearest pending floor (tie: lower floor). Go to UP if it is above `floor`, DOWN if below.
- UP:
  - `target` = lowest pending floor > `floor`.
  - On arrival, go to DWELL.
  - If no pending floor lies above, go to DOWN if any lies below, else IDLE.
- DOWN: mirror of UP. `target` = highest pending floor < `floor`.
- Arrival: `floor` == `target` and `pending[target]` = 1 while in UP or DOWN. On that edge:
  - clear `pending[target]`;
  - load the dwell counter with DWELL_CYCLES−1;
  - enter DWELL.
- DWELL:
  - `target_valid`=0, `door_open`=1, `target` holds the served floor.
  - The counter decrements each cycle. At 0, re-evaluate in the preserved direction:
    - continue the same direction if a pending floor lies beyond;
    - else reverse if any call is pending;
    - else go to IDLE.
- A call that appears for a floor between `floor` and `target` in the sweep direction retargets to the nearer floor on the next edge.
- `floor` changes are trusted. Out-of-range `floor` never produces an arrival.

## Timing
- Reset values (reset asserted on an edge, takes priority over everything, including mid-dwell):
  - state IDLE;
  - `pending`=0, `target`=0, `target_valid`=0, `door_open`=0, `dir_up`=1.
- All outputs are registered.
- Call-to-target latency:
  - edge 1 latches `pending`;
  - edge 2 updates `target`/`target_valid` and the state.
  - So `call` → `target_valid` takes 2 cycles.
- Arrival-to-dwell latency: 1 edge. `door_open` is high for exactly DWELL_CYCLES cycles, longer only if an absorbed call reloads the counter.
- Simultaneous arrival and a new call at another floor: the clear and the set both apply on the same edge.

## Structure
- Shared package `lift_pkg` holds:
  - the state enum (IDLE/UP/DOWN/DWELL);
  - `NUM_FLOORS`;
  - the floor-index width constant, shared with the lift controller.
- Sub-module `lift_scan_select` (combinational) takes `pending`, `floor` and `dir_up`. It returns the nearest-above and nearest-below pending floors, each with a found flag.

## Test plan
- Reset, then `call`=4'b1000 for 1 cycle with `floor`=0 → `pending`=1000 after 1 cycle; `target`=3, `target_valid`=1, `dir_up`=1 after 2 cycles.
- `floor` steps 0→3 with pending 1000 → `pending`=0, `door_open` high exactly 3 cycles, then IDLE with `target_valid`=0.
- At `floor`=1 heading up to 3, press `call[2]` → `target` becomes 2 next cycle; floor 2 is served before floor 3.
- At `floor`=2 moving UP, `pending`=0001 and 1000 → floor 3 is served first, then the lift reverses to DOWN and `target`=0.
- During dwell at floor 1, press `call[1]` → not latched; `door_open` extended to DWELL_CYCLES after the press.
- Assert `reset` mid-DWELL with `pending`=0110 → all outputs at their reset values on the next edge; `call` is ignored while `reset`=1.

Source files
------------

// File: rtl/lift_pkg.sv
// lift_pkg: definitions shared by the lift request scheduler and the lift
// controller it drives.
//   NUM_FLOORS   - number of floors served
//   FLOOR_W      - width of a floor index (the controller's `in` port)
//   POS_W        - width of the controller's `floor` position output
//   lift_state_e - scheduler sweep state
//   floor_mask() - one-hot mask for a floor index
package lift_pkg;

    localparam int NUM_FLOORS = 4;
    localparam int FLOOR_W    = $clog2(NUM_FLOORS);
    localparam int POS_W      = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        UP    = 2'd1,
        DOWN  = 2'd2,
        DWELL = 2'd3
    } lift_state_e;

    function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [FLOOR_W-1:0] f);
        floor_mask = {{(NUM_FLOORS-1){1'b0}}, 1'b1} << f;
    endfunction

endpackage

// File: rtl/lift_scan_select.sv
// lift_scan_select: combinational SCAN helper. Finds the nearest pending
// floor strictly above and strictly below the current floor, and presents
// them again as "ahead" and "behind" relative to the sweep direction.
// Ports:
//   pending        in  outstanding calls, one bit per floor
//   floor          in  current floor index
//   dir_up         in  sweep direction (1 = up)
//   above_found/above_floor    out lowest pending floor above `floor`
//   below_found/below_floor    out highest pending floor below `floor`
//   ahead_found/ahead_floor    out nearest pending floor in sweep direction
//   behind_found/behind_floor  out nearest pending floor against it
module lift_scan_select
    import lift_pkg::*;
(
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    floor,
    input  logic                  dir_up,
    output logic                  above_found,
    output logic [FLOOR_W-1:0]    above_floor,
    output logic                  below_found,
    output logic [FLOOR_W-1:0]    below_floor,
    output logic                  ahead_found,
    output logic [FLOOR_W-1:0]    ahead_floor,
    output logic                  behind_found,
    output logic [FLOOR_W-1:0]    behind_floor
);

    // Nearest pending floor above: scan top-down so the last hit is the lowest.
    always_comb begin
        above_found = 1'b0;
        above_floor = {FLOOR_W{1'b0}};
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (i > int'(floor))) begin
                above_found = 1'b1;
                above_floor = FLOOR_W'(i);
            end else begin
                above_found = above_found;
            end
        end
    end

    // Nearest pending floor below: scan bottom-up so the last hit is the highest.
    always_comb begin
        below_found = 1'b0;
        below_floor = {FLOOR_W{1'b0}};
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (i < int'(floor))) begin
                below_found = 1'b1;
                below_floor = FLOOR_W'(i);
            end else begin
                below_found = below_found;
            end
        end
    end

    // Re-express the two candidates relative to the sweep direction.
    always_comb begin
        if (dir_up) begin
            ahead_found  = above_found;
            ahead_floor  = above_floor;
            behind_found = below_found;
            behind_floor = below_floor;
        end else begin
            ahead_found  = below_found;
            ahead_floor  = below_floor;
            behind_found = above_found;
            behind_floor = above_floor;
        end
    end

endmodule

// File: rtl/lift_request_scheduler.sv
// lift_request_scheduler: latches hall/cab calls and schedules them with a
// direction-preserving SCAN sweep, requesting floors from the lift
// controller and holding a door-dwell interval on each arrival.
// Ports:
//   clk          in  clock, rising edge
//   reset        in  synchronous active-high reset
//   call         in  call buttons, one per floor
//   floor        in  current floor from the controller (out-of-range ignored)
//   target       out requested floor (controller `in`)
//   target_valid out target is a live request
//   door_open    out high during dwell
//   dir_up       out sweep direction (1 = up)
//   pending      out latched outstanding calls
module lift_request_scheduler
    import lift_pkg::*;
#(
    parameter int DWELL_CYCLES = 3
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call,
    input  logic [POS_W-1:0]      floor,
    output logic [FLOOR_W-1:0]    target,
    output logic                  target_valid,
    output logic                  door_open,
    output logic                  dir_up,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

    lift_state_e           state_r;
    lift_state_e           state_s;
    logic [CNT_W-1:0]      dwell_cnt_r;
    logic [CNT_W-1:0]      dwell_cnt_s;
    logic [FLOOR_W-1:0]    last_floor_r;
    logic [FLOOR_W-1:0]    target_s;
    logic                  target_valid_s;
    logic                  door_open_s;
    logic                  dir_up_s;
    logic [NUM_FLOORS-1:0] pending_s;
    logic [NUM_FLOORS-1:0] clear_s;
    logic [NUM_FLOORS-1:0] absorb_s;
    logic                  floor_ok_s;
    logic [FLOOR_W-1:0]    eff_floor_s;
    logic                  arrival_s;
    logic                  absorbed_s;
    logic                  pick_up_s;
    logic                  above_found_s;
    logic [FLOOR_W-1:0]    above_floor_s;
    logic                  below_found_s;
    logic [FLOOR_W-1:0]    below_floor_s;
    logic                  ahead_found_s;
    logic [FLOOR_W-1:0]    ahead_floor_s;
    logic                  behind_found_s;
    logic [FLOOR_W-1:0]    behind_floor_s;

    // An out-of-range position is treated as "lift still at the last valid floor".
    assign floor_ok_s  = (floor < POS_W'(NUM_FLOORS));
    assign eff_floor_s = floor_ok_s ? floor[FLOOR_W-1:0] : last_floor_r;

    // Full-width compare so an out-of-range floor can never alias onto target.
    assign arrival_s  = floor_ok_s && (floor == POS_W'(target)) && pending[target];

    // A call for the floor whose doors are open is absorbed into the dwell.
    assign absorbed_s = door_open && call[target];
    assign absorb_s   = door_open ? floor_mask(target) : {NUM_FLOORS{1'b0}};

    // From rest, head for the nearest call; equal distance favours the lower floor.
    assign pick_up_s = above_found_s &&
                       (!below_found_s ||
                        ((above_floor_s - eff_floor_s) < (eff_floor_s - below_floor_s)));

    lift_scan_select u_scan (
        .pending      (pending),
        .floor        (eff_floor_s),
        .dir_up       (dir_up),
        .above_found  (above_found_s),
        .above_floor  (above_floor_s),
        .below_found  (below_found_s),
        .below_floor  (below_floor_s),
        .ahead_found  (ahead_found_s),
        .ahead_floor  (ahead_floor_s),
        .behind_found (behind_found_s),
        .behind_floor (behind_floor_s)
    );

    // Service clears win over a same-edge press at the served floor.
    assign pending_s = (pending | (call & ~absorb_s)) & ~clear_s;

    // Next-state and next-output decisions for the SCAN sweep.
    always_comb begin
        state_s        = state_r;
        target_s       = target;
        target_valid_s = target_valid;
        door_open_s    = door_open;
        dir_up_s       = dir_up;
        dwell_cnt_s    = dwell_cnt_r;
        clear_s        = {NUM_FLOORS{1'b0}};
        case (state_r)
            IDLE: begin
                if (floor_ok_s && (pending != {NUM_FLOORS{1'b0}})) begin
                    if (pending[eff_floor_s]) begin
                        state_s        = DWELL;
                        target_s       = eff_floor_s;
                        target_valid_s = 1'b0;
                        door_open_s    = 1'b1;
                        dwell_cnt_s    = DWELL_LOAD;
                        clear_s        = floor_mask(eff_floor_s);
                    end else if (pick_up_s) begin
                        state_s        = UP;
                        dir_up_s       = 1'b1;
                        target_s       = above_floor_s;
                        target_valid_s = 1'b1;
                    end else begin
                        state_s        = DOWN;
                        dir_up_s       = 1'b0;
                        target_s       = below_floor_s;
                        target_valid_s = 1'b1;
                    end
                end else begin
                    target_valid_s = 1'b0;
                end
            end
            UP, DOWN: begin
                if (!floor_ok_s) begin
                    state_s = state_r;
                end else if (arrival_s) begin
                    state_s        = DWELL;
                    target_valid_s = 1'b0;
                    door_open_s    = 1'b1;
                    dwell_cnt_s    = DWELL_LOAD;
                    clear_s        = floor_mask(target);
                end else if (ahead_found_s) begin
                    // Also covers retargeting to a nearer call on the way.
                    target_s       = ahead_floor_s;
                    target_valid_s = 1'b1;
                end else if (behind_found_s) begin
                    state_s        = dir_up ? DOWN : UP;
                    dir_up_s       = ~dir_up;
                    target_s       = behind_floor_s;
                    target_valid_s = 1'b1;
                end else begin
                    state_s        = IDLE;
                    target_valid_s = 1'b0;
                end
            end
            DWELL: begin
                if (absorbed_s) begin
                    dwell_cnt_s = DWELL_LOAD;
                end else if (dwell_cnt_r != {CNT_W{1'b0}}) begin
                    dwell_cnt_s = dwell_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    door_open_s = 1'b0;
                    if (ahead_found_s) begin
                        state_s        = dir_up ? UP : DOWN;
                        target_s       = ahead_floor_s;
                        target_valid_s = 1'b1;
                    end else if (behind_found_s) begin
                        state_s        = dir_up ? DOWN : UP;
                        dir_up_s       = ~dir_up;
                        target_s       = behind_floor_s;
                        target_valid_s = 1'b1;
                    end else begin
                        // A call left only at this floor is picked up from IDLE.
                        state_s        = IDLE;
                        target_valid_s = 1'b0;
                    end
                end
            end
            default: begin
                state_s        = IDLE;
                target_valid_s = 1'b0;
                door_open_s    = 1'b0;
            end
        endcase
    end

    // State, counter, call latch and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            dwell_cnt_r  <= {CNT_W{1'b0}};
            last_floor_r <= {FLOOR_W{1'b0}};
            pending      <= {NUM_FLOORS{1'b0}};
            target       <= {FLOOR_W{1'b0}};
            target_valid <= 1'b0;
            door_open    <= 1'b0;
            dir_up       <= 1'b1;
        end else begin
            state_r      <= state_s;
            dwell_cnt_r  <= dwell_cnt_s;
            last_floor_r <= eff_floor_s;
            pending      <= pending_s;
            target       <= target_s;
            target_valid <= target_valid_s;
            door_open    <= door_open_s;
            dir_up       <= dir_up_s;
        end
    end

endmodule
